// File: rtl/sub_mod_sched.sv
// Round-robin scheduler sharing one pipelined modular subtractor among NREQ requesters.
// Optional feature macro: SUB_SCHED_LAT_CHECK_EN (sticky latency-mismatch flag on err_lat).
module sub_mod_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 11,
    parameter int W    = 378
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*W-1:0]        req_a,
    input  logic [NREQ*W-1:0]        req_b,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [W-1:0]             rsp_data,
    output logic                     rsp_neg,
    output logic                     sub_valid,
    output logic [W-1:0]             sub_in0,
    output logic [W-1:0]             sub_in1,
    input  logic                     sub_valid_out,
    input  logic [W-1:0]             sub_out,
    input  logic                     sub_sel_out,
    input  logic                     sub_idle,
    input  logic                     drain_req,
    output logic                     drain_done,
    output logic                     idle,
    output logic                     err_lat,
    output logic [1:0]               state_dbg,
    output logic [$clog2(LAT+4)-1:0] inflight_dbg
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(LAT+4);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
    logic                    sub_valid_q, sub_valid_d;
    logic [W-1:0]            sub_in0_q, sub_in0_d;
    logic [W-1:0]            sub_in1_q, sub_in1_d;
    logic [LAT:0]            tag_vld_q, tag_vld_d;
    logic [LAT:0][IDW-1:0]   tag_id_q, tag_id_d;
    logic [NREQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [W-1:0]            rsp_data_q, rsp_data_d;
    logic                    rsp_neg_q, rsp_neg_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic                    grant_vld;
    logic [IDW-1:0]          grant_id;
    logic [IDW:0]            scan_sum;
    logic                    tail_vld;
    logic [IDW-1:0]          tail_id;
    logic                    rsp_fire;

    // Handshake: requester i transfers in a cycle where req_valid[i] and req_ready[i]
    // are both high; req_ready is combinational from req_valid, rr_ptr, state and drain_req.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_sum  = '0;
        if (state_q == S_RUN && !drain_req) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
                if (scan_sum >= (IDW+1)'(NREQ)) scan_sum = scan_sum - (IDW+1)'(NREQ);
                if (!grant_vld && req_valid[scan_sum[IDW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_id  = scan_sum[IDW-1:0];
                end
            end
        end
    end

    assign req_ready = grant_vld ? (NREQ'(1) << grant_id) : '0;

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        sub_valid_d = grant_vld;
        sub_in0_d   = sub_in0_q;
        sub_in1_d   = sub_in1_q;
        if (grant_vld) begin
            rr_ptr_d  = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + 1'b1;
            sub_in0_d = req_a[grant_id*W +: W];
            sub_in1_d = req_b[grant_id*W +: W];
        end
    end

    // Stage 0 loads with sub_valid, so stage LAT lines up with sub_valid_out.
    assign tag_vld_d = {tag_vld_q[LAT-1:0], grant_vld};
    assign tag_id_d  = {tag_id_q[LAT-1:0], grant_id};
    assign tail_vld  = tag_vld_q[LAT];
    assign tail_id   = tag_id_q[LAT];

`ifdef SUB_SCHED_LAT_CHECK_EN
    assign rsp_fire = sub_valid_out & tail_vld;
`else
    assign rsp_fire = sub_valid_out;
`endif

    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_neg_d   = rsp_neg_q;
        if (rsp_fire) begin
            rsp_valid_d = NREQ'(1) << tail_id;
            rsp_data_d  = sub_out;
            rsp_neg_d   = sub_sel_out;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (grant_vld && !(|rsp_valid_q)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!grant_vld && (|rsp_valid_q) && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (drain_req) state_d = S_DRAIN;
            S_DRAIN: if (cnt_q == '0 && sub_idle) state_d = S_HALT;
            S_HALT:  if (!drain_req) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q     <= S_RUN;
            rr_ptr_q    <= '0;
            sub_valid_q <= 1'b0;
            sub_in0_q   <= '0;
            sub_in1_q   <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_neg_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            sub_valid_q <= sub_valid_d;
            sub_in0_q   <= sub_in0_d;
            sub_in1_q   <= sub_in1_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_neg_q   <= rsp_neg_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef SUB_SCHED_LAT_CHECK_EN
    logic err_lat_q, err_lat_d;

    // Any disagreement between the subtractor strobe and the tag tail is latched.
    assign err_lat_d = err_lat_q | (sub_valid_out ^ tail_vld);

    always_ff @(posedge clk) begin
        if (!rstN) err_lat_q <= 1'b0;
        else       err_lat_q <= err_lat_d;
    end

    assign err_lat = err_lat_q;
`else
    assign err_lat = 1'b0;
`endif

    assign sub_valid    = sub_valid_q;
    assign sub_in0      = sub_in0_q;
    assign sub_in1      = sub_in1_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_neg      = rsp_neg_q;
    assign drain_done   = (state_q == S_HALT);
    assign idle         = (cnt_q == '0) && (tag_vld_q == '0) && sub_idle;
    assign state_dbg    = state_q;
    assign inflight_dbg = cnt_q;

endmodule

// File: tb/tb_sub_mod_sched.sv
// Self-checking bench for sub_mod_sched with a behavioural pipelined modular subtractor.
// Exercises SUB_SCHED_LAT_CHECK_EN behaviour when that macro is defined.
module tb_sub_mod_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 11;
  localparam int W    = 378;
  localparam int CW   = $clog2(LAT+4);
  localparam logic [W-1:0] P = {1'b0, {(W-1){1'b1}}};

  logic              clk;
  logic              rstN;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_data;
  logic              rsp_neg;
  logic              sub_valid;
  logic [W-1:0]      sub_in0;
  logic [W-1:0]      sub_in1;
  logic              sub_valid_out;
  logic [W-1:0]      sub_out;
  logic              sub_sel_out;
  logic              sub_idle;
  logic              drain_req;
  logic              drain_done;
  logic              idle;
  logic              err_lat;
  logic [1:0]        state_dbg;
  logic [CW-1:0]     inflight_dbg;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [NREQ-1:0] oh;
    logic [W-1:0]    data;
    logic            neg;
    int              due;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] ready;
  } vec_t;
  vec_t vecs[14];

  sub_mod_sched #(.NREQ(NREQ), .LAT(LAT), .W(W)) dut (
    .clk(clk), .rstN(rstN),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_neg(rsp_neg),
    .sub_valid(sub_valid), .sub_in0(sub_in0), .sub_in1(sub_in1),
    .sub_valid_out(sub_valid_out), .sub_out(sub_out), .sub_sel_out(sub_sel_out),
    .sub_idle(sub_idle), .drain_req(drain_req), .drain_done(drain_done),
    .idle(idle), .err_lat(err_lat),
    .state_dbg(state_dbg), .inflight_dbg(inflight_dbg)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference subtractor ----------------
  function automatic logic [W-1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a >= b) return a - b;
    return a + (P - b);
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] r;
    r = '0;
    if ($urandom_range(0, 3) == 0) return W'($urandom_range(0, 20));
    for (int k = 0; k < 12; k++) r = {r[W-33:0], 32'($urandom())};
    r[W-1] = 1'b0;
    return r;
  endfunction

  logic [LAT:0]  mp_v;
  logic [LAT:0]  mp_s;
  logic [W-1:0]  mp_d [0:LAT];
  logic          extra_lat;
  logic [3:0]    tap;

  always @(posedge clk) begin
    if (!rstN) mp_v <= '0;
    else       mp_v <= {mp_v[LAT-1:0], sub_valid};
    mp_d[0] <= ref_sub(sub_in0, sub_in1);
    mp_s[0] <= (sub_in0 < sub_in1);
    for (int k = 1; k <= LAT; k++) begin
      mp_d[k] <= mp_d[k-1];
      mp_s[k] <= mp_s[k-1];
    end
  end

  assign tap           = extra_lat ? 4'(LAT) : 4'(LAT-1);
  assign sub_valid_out = mp_v[tap];
  assign sub_out       = mp_d[tap];
  assign sub_sel_out   = mp_s[tap];
  assign sub_idle      = extra_lat ? (mp_v == '0) : (mp_v[LAT-1:0] == '0);

  // ---------------- checking ----------------
  task automatic check_i(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic check_w(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Scoreboard: every response strobe must match the oldest expected entry, on its due cycle.
  always @(negedge clk) begin
    if (rstN) begin
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check_i("unexpected rsp_valid", 32'(rsp_valid), 32'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check_i("rsp_valid onehot", 32'(rsp_valid), 32'(mon_e.oh));
          check_w("rsp_data", rsp_data, mon_e.data);
          check_i("rsp_neg", 32'(rsp_neg), 32'(mon_e.neg));
          check_i("rsp cycle", 32'(cyc), 32'(mon_e.due));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
        check_i("rsp overdue", 32'(cyc), 32'(exp_q[0].due));
        mon_e = exp_q.pop_front();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ops(input logic fixed, input logic [W-1:0] fa, input logic [W-1:0] fb);
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*W +: W] = fixed ? fa : rand_op();
      req_b[i*W +: W] = fixed ? fb : rand_op();
    end
  endtask

  task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] rdy, input logic push,
                       input logic fixed, input logic [W-1:0] fa, input logic [W-1:0] fb,
                       input string name);
    req_valid = v;
    set_ops(fixed, fa, fb);
    #1;
    check_i(name, 32'(req_ready), 32'(rdy));
    if (push) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rdy[i]) exp_q.push_back('{rdy, ref_sub(req_a[i*W +: W], req_b[i*W +: W]),
                                      (req_a[i*W +: W] < req_b[i*W +: W]), cyc + LAT + 2});
      end
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_i("queue drained", 32'(exp_q.size()), 32'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] pm2;
    logic         saw_rdy;
    int           n;

    rstN      = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    drain_req = 1'b0;
    extra_lat = 1'b0;
    pm2       = P - W'(2);

    vecs[0]  = '{4'b0100, 4'b0100};
    vecs[1]  = '{4'b0000, 4'b0000};
    vecs[2]  = '{4'b0011, 4'b0001};
    vecs[3]  = '{4'b0011, 4'b0010};
    vecs[4]  = '{4'b1001, 4'b1000};
    vecs[5]  = '{4'b1111, 4'b0001};
    vecs[6]  = '{4'b0001, 4'b0001};
    vecs[7]  = '{4'b1100, 4'b0100};
    vecs[8]  = '{4'b0110, 4'b0010};
    vecs[9]  = '{4'b1010, 4'b1000};
    vecs[10] = '{4'b1000, 4'b1000};
    vecs[11] = '{4'b0101, 4'b0001};
    vecs[12] = '{4'b0101, 4'b0100};
    vecs[13] = '{4'b1110, 4'b1000};

    // reset values
    repeat (3) @(negedge clk);
    #1;
    check_i("reset req_ready", 32'(req_ready), 32'(0));
    check_i("reset sub_valid", 32'(sub_valid), 32'(0));
    check_w("reset sub_in0", sub_in0, '0);
    check_w("reset sub_in1", sub_in1, '0);
    check_i("reset rsp_valid", 32'(rsp_valid), 32'(0));
    check_w("reset rsp_data", rsp_data, '0);
    check_i("reset rsp_neg", 32'(rsp_neg), 32'(0));
    check_i("reset drain_done", 32'(drain_done), 32'(0));
    check_i("reset err_lat", 32'(err_lat), 32'(0));
    check_i("reset idle", 32'(idle), 32'(1));
    check_i("reset inflight", 32'(inflight_dbg), 32'(0));
    rstN = 1'b1;
    @(negedge clk);

    // single request on requester 2: 5 - 3
    cycle(4'b0100, 4'b0100, 1'b1, 1'b1, W'(5), W'(3), "single grant");
    #1;
    check_i("single sub_valid", 32'(sub_valid), 32'(1));
    check_w("single sub_in0", sub_in0, W'(5));
    check_w("single sub_in1", sub_in1, W'(3));
    check_i("single inflight", 32'(inflight_dbg), 32'(1));
    @(negedge clk);
    #1;
    check_i("sub_valid one cycle", 32'(sub_valid), 32'(0));
    check_w("sub_in0 held", sub_in0, W'(5));
    wait_empty(LAT + 6);
    check_w("single rsp_data", rsp_data, W'(2));
    check_i("single rsp_neg", 32'(rsp_neg), 32'(0));

    // borrow: 3 - 5 wraps to p-2
    cycle(4'b0100, 4'b0100, 1'b1, 1'b1, W'(3), W'(5), "borrow grant");
    wait_empty(LAT + 6);
    check_w("borrow rsp_data", rsp_data, pm2);
    check_i("borrow rsp_neg", 32'(rsp_neg), 32'(1));

    // table-driven grant patterns, rr_ptr starts at 3 here
    for (int i = 0; i < 14; i++) begin
      cycle(vecs[i].valid, vecs[i].ready, 1'b1, 1'b0, '0, '0, $sformatf("table[%0d] grant", i));
    end

    // fairness: all requesters for 12 cycles
    for (int k = 0; k < 12; k++) begin
      cycle(4'b1111, 4'b0001 << (k % 4), 1'b1, 1'b0, '0, '0, $sformatf("fair[%0d] grant", k));
    end
    wait_empty(LAT + 8);

    // drain with 5 in flight
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1111, 4'b0001 << (k % 4), 1'b1, 1'b0, '0, '0, $sformatf("pre-drain[%0d]", k));
    end
    drain_req = 1'b1;
    req_valid = 4'b1111;
    #1;
    check_i("drain grant suppressed", 32'(req_ready), 32'(0));
    check_i("drain inflight", 32'(inflight_dbg), 32'(5));
    check_i("drain not done yet", 32'(drain_done), 32'(0));
    n = 0;
    saw_rdy = 1'b0;
    while (!drain_done && n < LAT + 8) begin
      @(negedge clk);
      #1;
      saw_rdy = saw_rdy | (|req_ready);
      n++;
    end
    check_i("drain_done reached", 32'(drain_done), 32'(1));
    check_i("no grant while draining", 32'(saw_rdy), 32'(0));
    check_i("drain responses all back", 32'(exp_q.size()), 32'(0));
    check_i("halt idle", 32'(idle), 32'(1));
    check_i("halt state", 32'(state_dbg), 32'(2));
    drain_req = 1'b0;
    req_valid = 4'b0001;
    #1;
    check_i("halt exit cycle ready", 32'(req_ready), 32'(0));
    check_i("halt exit cycle done", 32'(drain_done), 32'(1));
    @(negedge clk);
    cycle(4'b0001, 4'b0001, 1'b1, 1'b0, '0, '0, "resume grant");
    check_i("resume drain_done", 32'(drain_done), 32'(0));
    wait_empty(LAT + 6);

    // drain_req dropped while in DRAIN still completes to HALT
    drain_req = 1'b1;
    @(negedge clk);
    drain_req = 1'b0;
    #1;
    check_i("short drain state", 32'(state_dbg), 32'(1));
    check_i("short drain done low", 32'(drain_done), 32'(0));
    @(negedge clk);
    #1;
    check_i("short drain halted", 32'(drain_done), 32'(1));
    @(negedge clk);
    #1;
    check_i("short drain resumed", 32'(drain_done), 32'(0));
    check_i("short drain run state", 32'(state_dbg), 32'(0));

    // reset mid-stream with 6 in flight
    for (int k = 0; k < 6; k++) begin
      cycle(4'b1111, 4'b0001 << ((k + 1) % 4), 1'b1, 1'b0, '0, '0, $sformatf("pre-reset[%0d]", k));
    end
    #1;
    check_i("pre-reset inflight", 32'(inflight_dbg), 32'(6));
    rstN = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    rstN = 1'b1;
    check_i("mid reset inflight", 32'(inflight_dbg), 32'(0));
    check_i("mid reset state", 32'(state_dbg), 32'(0));
    check_i("mid reset sub_valid", 32'(sub_valid), 32'(0));
    check_i("mid reset rsp_valid", 32'(rsp_valid), 32'(0));
    repeat (LAT + 4) @(negedge clk);
    #1;
    check_i("post-reset idle", 32'(idle), 32'(1));
    check_i("post-reset inflight", 32'(inflight_dbg), 32'(0));
    cycle(4'b1111, 4'b0001, 1'b1, 1'b0, '0, '0, "post-reset grant");
    wait_empty(LAT + 6);

`ifdef SUB_SCHED_LAT_CHECK_EN
    // subtractor one cycle slower than LAT
    extra_lat = 1'b1;
    cycle(4'b0100, 4'b0100, 1'b0, 1'b0, '0, '0, "latcheck grant");
    n = 0;
    while (!err_lat && n < LAT + 6) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_i("err_lat set", 32'(err_lat), 32'(1));
    repeat (4) @(negedge clk);
    #1;
    check_i("err_lat sticky", 32'(err_lat), 32'(1));
    rstN = 1'b0;
    extra_lat = 1'b0;
    @(negedge clk);
    #1;
    rstN = 1'b1;
    check_i("err_lat cleared by reset", 32'(err_lat), 32'(0));
`else
    check_i("err_lat tied low", 32'(err_lat), 32'(0));
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
